mem_port_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 55 +++++
 rtl/mem_port_arbiter_rr_arb2.sv | 32 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the memory-port arbiter: default bus widths,
// requester identifiers and the CPU-hold state encoding.
package cpu_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    typedef enum logic [1:0] {
        REQ_CPU = 2'd0,
        REQ_DBG = 2'd1,
        REQ_LD  = 2'd2
    } req_e;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_HOLD   = 2'd1,
        ST_DRAIN  = 2'd2
    } hold_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU, debug-reader, loader and memory-side signals of the shared port.
interface mem_port_arbiter_if
#(
    parameter int AW = cpu_pkg::AW_DEF,
    parameter int DW = cpu_pkg::DW_DEF
);
    logic          cpu_re;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_idle;
    logic          cpu_hold;

    logic          dbg_req;
    logic [AW-1:0] dbg_addr;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // Requesters and memory side.
    modport master (
        output cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_idle,
        input  cpu_rdata, cpu_hold,
        output dbg_req, dbg_addr,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

    // Arbiter side.
    modport slave (
        input  cpu_re, cpu_we, cpu_addr, cpu_wdata, cpu_idle,
        output cpu_rdata, cpu_hold,
        input  dbg_req, dbg_addr,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between the debug reader and the loader.
// The pointer remembers the last tie winner; only ties move it.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_dbg,
    input  logic i_req_ld,
    output logic o_gnt_dbg,
    output logic o_gnt_ld
);

    req_e r_ptr;
    logic w_tie;
    logic w_pick_dbg;

    assign w_tie      = i_req_dbg & i_req_ld;
    assign w_pick_dbg = i_req_dbg & (~i_req_ld | (r_ptr != REQ_DBG));
    assign o_gnt_dbg  = i_en & w_pick_dbg;
    assign o_gnt_ld   = i_en & i_req_ld & ~w_pick_dbg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= REQ_LD;
        end else if (i_en && w_tie) begin
            r_ptr <= w_pick_dbg ? REQ_DBG : REQ_LD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between the CPU (absolute priority),
// the debug reader and the loader, with a starvation-driven CPU hold.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int STARVE_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic        w_cpu_acc;
    logic        w_dbg_gnt;
    logic        w_ld_gnt;
    logic        w_side_req;
    logic        w_side_gnt;
    logic        w_hold;
    logic [7:0]  r_starve;
    logic        r_dbg_vld_p1;
    hold_state_e r_state;
    hold_state_e w_state_nxt;

    assign w_cpu_acc  = bus.cpu_re | bus.cpu_we;
    assign w_side_req = bus.dbg_req | bus.ld_req;
    assign w_side_gnt = w_dbg_gnt | w_ld_gnt;

    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .i_en      (~w_cpu_acc),
        .i_req_dbg (bus.dbg_req),
        .i_req_ld  (bus.ld_req),
        .o_gnt_dbg (w_dbg_gnt),
        .o_gnt_ld  (w_ld_gnt)
    );

    assign bus.dbg_gnt   = w_dbg_gnt;
    assign bus.ld_gnt    = w_ld_gnt;
    assign bus.cpu_rdata = bus.mem_rdata;
    assign bus.dbg_rdata = bus.mem_rdata;

    // CPU drive is the default; grants are already masked during CPU cycles.
    always_comb begin
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_we    = bus.cpu_we;
        bus.mem_wdata = bus.cpu_wdata;
        if (w_dbg_gnt) begin
            bus.mem_addr = bus.dbg_addr;
            bus.mem_we   = 1'b0;
        end else if (w_ld_gnt) begin
            bus.mem_addr  = bus.ld_addr;
            bus.mem_we    = 1'b1;
            bus.mem_wdata = bus.ld_wdata;
        end
    end

    // Stage p0 -> p1: read data from the memory arrives one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg_vld_p1 <= 1'b0;
        end else begin
            r_dbg_vld_p1 <= w_dbg_gnt;
        end
    end

    assign bus.dbg_rvalid = r_dbg_vld_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= 8'd0;
        end else if (!w_side_req || w_side_gnt) begin
            r_starve <= 8'd0;
        end else if (r_starve != STARVE_LIM) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Entering DRAIN takes precedence over the quiet-CPU return to NORMAL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: begin
                if (r_starve == STARVE_LIM) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.cpu_idle && !w_cpu_acc) w_state_nxt = ST_DRAIN;
                else if (w_side_gnt)            w_state_nxt = ST_NORMAL;
            end
            ST_DRAIN: begin
                if (!w_side_req) w_state_nxt = ST_NORMAL;
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    always_comb begin
        w_hold = (r_state != ST_NORMAL);
    end

    assign bus.cpu_hold = w_hold;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus hand sequences,
// with a read-data scoreboard fed at grant time and drained on dbg_rvalid.
module tb_mem_port_arbiter;
    import cpu_pkg::*;

    localparam int AW   = 8;
    localparam int DW   = 32;
    localparam int SMAX = 16;

    typedef struct {
        logic          cre, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          idle, dreq;
        logic [AW-1:0] daddr;
        logic          lreq;
        logic [AW-1:0] laddr;
        logic [DW-1:0] lwd;
        logic          e_dg, e_lg, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_rv;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] sb_exp;
    vec_t          vt [$];

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous-read memory model.
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard drain.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.dbg_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("dbg_rdata", bus.dbg_rdata, sb_exp);
            end
        end
    end

    function automatic vec_t mk(int cre, int cwe, int caddr, int cwd, int idle,
                                int dreq, int daddr, int lreq, int laddr, int lwd,
                                int edg, int elg, int ewe, int eaddr, int ewd, int erv);
        vec_t v;
        v.cre = 1'(cre);    v.cwe = 1'(cwe);    v.caddr = AW'(caddr); v.cwd = DW'(cwd);
        v.idle = 1'(idle);  v.dreq = 1'(dreq);  v.daddr = AW'(daddr);
        v.lreq = 1'(lreq);  v.laddr = AW'(laddr); v.lwd = DW'(lwd);
        v.e_dg = 1'(edg);   v.e_lg = 1'(elg);   v.e_we = 1'(ewe);
        v.e_addr = AW'(eaddr); v.e_wd = DW'(ewd); v.e_rv = 1'(erv);
        return v;
    endfunction

    task automatic idle_inputs();
        bus.cpu_re = 1'b0;  bus.cpu_we = 1'b0;  bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.cpu_idle = 1'b1;
        bus.dbg_req = 1'b0; bus.dbg_addr = '0;
        bus.ld_req = 1'b0;  bus.ld_addr = '0;   bus.ld_wdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        mem[8'h10]     = 32'h1234_5678;
        ref_mem[8'h10] = 32'h1234_5678;

        //       cre cwe caddr cwd   idl dreq daddr lreq laddr lwd   dg lg we eaddr ewd   rv
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h10, 0, 'h00, 'h00, 1, 0, 0, 'h10, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 0, 'h00, 0, 'h00, 'h00, 0, 0, 0, 'h00, 'h00, 1));
        vt.push_back(mk(1, 0, 'h04, 'h00, 0, 0, 'h00, 1, 'h20, 'hAA, 0, 0, 0, 'h04, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 0, 'h00, 1, 'h20, 'hAA, 0, 1, 1, 'h20, 'hAA, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h20, 0, 'h00, 'h00, 1, 0, 0, 'h20, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h30, 1, 'h40, 'h11, 1, 0, 0, 'h30, 'h00, 1));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h30, 1, 'h40, 'h11, 0, 1, 1, 'h40, 'h11, 1));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h30, 1, 'h44, 'h22, 1, 0, 0, 'h30, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h30, 1, 'h44, 'h22, 0, 1, 1, 'h44, 'h22, 1));
        vt.push_back(mk(1, 1, 'h08, 'h55, 0, 0, 'h00, 0, 'h00, 'h00, 0, 0, 1, 'h08, 'h55, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 1, 'h08, 0, 'h00, 'h00, 1, 0, 0, 'h08, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 0, 'h00, 0, 'h00, 'h00, 0, 0, 0, 'h00, 'h00, 1));
        vt.push_back(mk(1, 0, 'h30, 'h00, 0, 1, 'h30, 1, 'h48, 'h33, 0, 0, 0, 'h30, 'h00, 0));
        vt.push_back(mk(0, 0, 'h00, 'h00, 1, 0, 'h00, 0, 'h00, 'h00, 0, 0, 0, 'h00, 'h00, 0));

        // Reset
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("rst_hold", 32'(bus.cpu_hold), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Vector table
        foreach (vt[i]) begin
            bus.cpu_re = vt[i].cre;     bus.cpu_we = vt[i].cwe;
            bus.cpu_addr = vt[i].caddr; bus.cpu_wdata = vt[i].cwd;
            bus.cpu_idle = vt[i].idle;
            bus.dbg_req = vt[i].dreq;   bus.dbg_addr = vt[i].daddr;
            bus.ld_req = vt[i].lreq;    bus.ld_addr = vt[i].laddr; bus.ld_wdata = vt[i].lwd;
            @(negedge clk);
            check($sformatf("v%0d_dbg_gnt", i), 32'(bus.dbg_gnt), 32'(vt[i].e_dg));
            check($sformatf("v%0d_ld_gnt", i), 32'(bus.ld_gnt), 32'(vt[i].e_lg));
            check($sformatf("v%0d_mem_we", i), 32'(bus.mem_we), 32'(vt[i].e_we));
            check($sformatf("v%0d_mem_addr", i), 32'(bus.mem_addr), 32'(vt[i].e_addr));
            check($sformatf("v%0d_rvalid", i), 32'(bus.dbg_rvalid), 32'(vt[i].e_rv));
            if (vt[i].e_we) begin
                check($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, vt[i].e_wd);
                ref_mem[vt[i].e_addr] = vt[i].e_wd;
            end
            if (vt[i].e_dg) sb.push_back(ref_mem[vt[i].daddr]);
            next_cycle();
        end

        // CPU read passes straight through
        idle_inputs();
        bus.cpu_re = 1'b1;
        bus.cpu_addr = 8'h10;
        next_cycle();
        bus.cpu_re = 1'b0;
        @(negedge clk);
        check("cpu_rdata", bus.cpu_rdata, ref_mem[8'h10]);
        next_cycle();

        // Starvation hold and drain
        idle_inputs();
        bus.cpu_re = 1'b1;
        bus.cpu_idle = 1'b0;
        bus.dbg_req = 1'b1;
        bus.dbg_addr = 8'h10;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("starve_hold_c%0d", c), 32'(bus.cpu_hold), 32'(c >= SMAX + 1));
            check("starve_no_gnt", 32'(bus.dbg_gnt), 32'd0);
            next_cycle();
        end
        bus.cpu_re = 1'b0;
        bus.cpu_idle = 1'b1;
        @(negedge clk);
        check("hold_release_gnt", 32'(bus.dbg_gnt), 32'd1);
        check("hold_still_set", 32'(bus.cpu_hold), 32'd1);
        sb.push_back(ref_mem[8'h10]);
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("drain_hold", 32'(bus.cpu_hold), 32'd1);
        next_cycle();
        @(negedge clk);
        check("drain_done_hold", 32'(bus.cpu_hold), 32'd0);
        next_cycle();

        // Reset mid-read while held, with the pointer moved to DBG
        idle_inputs();
        bus.dbg_req = 1'b1; bus.dbg_addr = 8'h10;
        bus.ld_req = 1'b1;  bus.ld_addr = 8'h50; bus.ld_wdata = 32'h77;
        @(negedge clk);
        check("tie_pre_dbg", 32'(bus.dbg_gnt), 32'd1);
        check("tie_pre_ld", 32'(bus.ld_gnt), 32'd0);
        sb.push_back(ref_mem[8'h10]);
        next_cycle();
        bus.ld_req = 1'b0;
        bus.cpu_re = 1'b1;
        bus.cpu_idle = 1'b0;
        for (int c = 0; c < SMAX + 2; c++) next_cycle();
        @(negedge clk);
        check("rehold", 32'(bus.cpu_hold), 32'd1);
        next_cycle();
        bus.cpu_re = 1'b0;
        bus.cpu_idle = 1'b1;
        @(negedge clk);
        check("rehold_gnt", 32'(bus.dbg_gnt), 32'd1);
        sb.push_back(ref_mem[8'h10]);
        next_cycle();
        rst = 1'b1;
        sb.delete();
        next_cycle();
        rst = 1'b0;
        bus.ld_req = 1'b1;
        @(negedge clk);
        check("post_rst_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check("post_rst_hold", 32'(bus.cpu_hold), 32'd0);
        check("post_rst_tie_dbg", 32'(bus.dbg_gnt), 32'd1);
        check("post_rst_tie_ld", 32'(bus.ld_gnt), 32'd0);
        sb.push_back(ref_mem[8'h10]);
        next_cycle();
        bus.dbg_req = 1'b0;
        @(negedge clk);
        check("post_rst_ld_gnt", 32'(bus.ld_gnt), 32'd1);
        check("post_rst_ld_addr", 32'(bus.mem_addr), 32'h50);
        next_cycle();
        idle_inputs();
        next_cycle();
        next_cycle();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
